hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage RV32I core (IF, ID, EX, MEM, WB).
- Takes per-instruction decode fields from the ID-stage decoder, plus branch/jump resolution from EX and a data-memory wait signal.
- Keeps an internal scoreboard of in-flight destination registers for the EX, MEM and WB slots.
- From that scoreboard it drives PC/IF-ID write enables, flush, bubble insertion, pipeline freeze, ALU operand forwarding selects, and stall/flush performance counters.

---
 rtl/hazard_ctrl_if.sv | 43 ++++
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Connection bundle between the ID-stage decoder, the EX/MEM resolution signals
// and the pipeline sequencing controller.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  // Every signal is a level that is sampled or driven in each cycle. There is no
  // valid/ready pair. i_id_valid qualifies the ID fields. i_mem_busy holds the
  // whole pipeline.
  logic             i_id_valid;
  logic [4:0]       i_id_rs1;
  logic [4:0]       i_id_rs2;
  logic             i_id_use_rs1;
  logic             i_id_use_rs2;
  logic [4:0]       i_id_rd;
  logic             i_id_rd_wen;
  logic             i_id_is_load;
  logic             i_ex_redirect;
  logic             i_mem_busy;

  logic             o_pc_wen;
  logic             o_ifid_wen;
  logic             o_ifid_flush;
  logic             o_idex_bubble;
  logic             o_freeze;
  logic [1:0]       o_fwd_a;
  logic [1:0]       o_fwd_b;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;

  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
           i_id_rd, i_id_rd_wen, i_id_is_load, i_ex_redirect, i_mem_busy,
    input  o_pc_wen, o_ifid_wen, o_ifid_flush, o_idex_bubble, o_freeze,
           o_fwd_a, o_fwd_b, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
           i_id_rd, i_id_rd_wen, i_id_is_load, i_ex_redirect, i_mem_busy,
    output o_pc_wen, o_ifid_wen, o_ifid_flush, o_idex_bubble, o_freeze,
           o_fwd_a, o_fwd_b, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core. It tracks the EX, MEM
// and WB instructions and decides stalls, flushes, freezes and operand forwarding.
module hazard_ctrl #(
  parameter bit BYPASS       = 1'b1,
  parameter bit RF_WB_BYPASS = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       rd_wen;
    logic       is_load;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
  } slot_t;

  slot_t ex_q, mem_q, wb_q;
  slot_t id_slot, ex_next;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic hazard, stall_inc, flush_inc, freeze;

  // x0 is hard-wired zero, so a write to x0 never produces a value to wait for.
  function automatic logic slot_match(slot_t s, logic [4:0] src, logic use_src);
    return s.valid & s.rd_wen & (s.rd != 5'd0) & (s.rd == src) & use_src;
  endfunction

  function automatic logic [1:0] fwd_sel(logic [4:0] src, logic use_src);
    logic [1:0] sel;
    sel = 2'b00;
    if (BYPASS) begin
      if (slot_match(mem_q, src, use_src))     sel = 2'b01;
      else if (slot_match(wb_q, src, use_src)) sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    id_slot         = '0;
    id_slot.valid   = bus.i_id_valid;
    if (bus.i_id_valid) begin
      id_slot.rd      = bus.i_id_rd;
      id_slot.rd_wen  = bus.i_id_rd_wen;
      id_slot.is_load = bus.i_id_is_load;
      id_slot.rs1     = bus.i_id_rs1;
      id_slot.rs2     = bus.i_id_rs2;
      id_slot.use_rs1 = bus.i_id_use_rs1;
      id_slot.use_rs2 = bus.i_id_use_rs2;
    end
  end

  // Without forwarding, ID waits until the producer has left every checked slot.
  always_comb begin
    hazard = 1'b0;
    if (BYPASS) begin
      hazard = ex_q.is_load &
               (slot_match(ex_q, bus.i_id_rs1, bus.i_id_use_rs1) |
                slot_match(ex_q, bus.i_id_rs2, bus.i_id_use_rs2));
    end else begin
      hazard = slot_match(ex_q,  bus.i_id_rs1, bus.i_id_use_rs1) |
               slot_match(ex_q,  bus.i_id_rs2, bus.i_id_use_rs2) |
               slot_match(mem_q, bus.i_id_rs1, bus.i_id_use_rs1) |
               slot_match(mem_q, bus.i_id_rs2, bus.i_id_use_rs2) |
               (!RF_WB_BYPASS &
                (slot_match(wb_q, bus.i_id_rs1, bus.i_id_use_rs1) |
                 slot_match(wb_q, bus.i_id_rs2, bus.i_id_use_rs2)));
    end
    hazard = hazard & bus.i_id_valid;
  end

  // Priority order: memory wait, then redirect, then data hazard.
  always_comb begin
    bus.o_pc_wen      = 1'b1;
    bus.o_ifid_wen    = 1'b1;
    bus.o_ifid_flush  = 1'b0;
    bus.o_idex_bubble = 1'b0;
    freeze            = 1'b0;
    stall_inc         = 1'b0;
    flush_inc         = 1'b0;
    ex_next           = id_slot;
    if (bus.i_mem_busy) begin
      freeze         = 1'b1;
      bus.o_pc_wen   = 1'b0;
      bus.o_ifid_wen = 1'b0;
    end else if (bus.i_ex_redirect) begin
      bus.o_ifid_flush  = 1'b1;
      bus.o_idex_bubble = 1'b1;
      ex_next           = '0;
      flush_inc         = 1'b1;
    end else if (hazard) begin
      bus.o_pc_wen      = 1'b0;
      bus.o_ifid_wen    = 1'b0;
      bus.o_idex_bubble = 1'b1;
      ex_next           = '0;
      stall_inc         = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!freeze) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_next;
      if (stall_inc) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.o_freeze    = freeze;
  assign bus.o_fwd_a     = fwd_sel(ex_q.rs1, ex_q.valid & ex_q.use_rs1);
  assign bus.o_fwd_b     = fwd_sel(ex_q.rs2, ex_q.valid & ex_q.use_rs2);
  assign bus.o_stall_cnt = stall_cnt_q;
  assign bus.o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Both a forwarding and a non-forwarding instance
// are driven from the same decode stimulus.
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   total_cnt = 0;

  logic       id_valid, use1, use2, rd_wen, is_load, redirect, busy;
  logic [4:0] rs1, rs2, rd;

  hazard_ctrl_if #(.CNT_W(32)) b1 ();
  hazard_ctrl_if #(.CNT_W(32)) b0 ();

  hazard_ctrl #(.BYPASS(1'b1), .RF_WB_BYPASS(1'b1), .CNT_W(32)) u1 (
    .i_clk(clk), .i_rst(rst), .bus(b1)
  );
  hazard_ctrl #(.BYPASS(1'b0), .RF_WB_BYPASS(1'b1), .CNT_W(32)) u0 (
    .i_clk(clk), .i_rst(rst), .bus(b0)
  );

  assign b1.i_id_valid = id_valid;  assign b0.i_id_valid = id_valid;
  assign b1.i_id_rs1 = rs1;         assign b0.i_id_rs1 = rs1;
  assign b1.i_id_rs2 = rs2;         assign b0.i_id_rs2 = rs2;
  assign b1.i_id_use_rs1 = use1;    assign b0.i_id_use_rs1 = use1;
  assign b1.i_id_use_rs2 = use2;    assign b0.i_id_use_rs2 = use2;
  assign b1.i_id_rd = rd;           assign b0.i_id_rd = rd;
  assign b1.i_id_rd_wen = rd_wen;   assign b0.i_id_rd_wen = rd_wen;
  assign b1.i_id_is_load = is_load; assign b0.i_id_is_load = is_load;
  assign b1.i_ex_redirect = redirect; assign b0.i_ex_redirect = redirect;
  assign b1.i_mem_busy = busy;      assign b0.i_mem_busy = busy;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the ID-stage decode fields.
  task automatic instr(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic u1_i, input logic u2_i, input logic [4:0] d,
                       input logic w, input logic ld);
    id_valid = v; rs1 = s1; rs2 = s2; use1 = u1_i; use2 = u2_i;
    rd = d; rd_wen = w; is_load = ld;
    #1;
  endtask

  task automatic idle();
    instr(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; busy = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // 1: reset state, idle
    chk("rst_pc_wen",    32'(b1.o_pc_wen), 1);
    chk("rst_ifid_wen",  32'(b1.o_ifid_wen), 1);
    chk("rst_flush",     32'(b1.o_ifid_flush), 0);
    chk("rst_bubble",    32'(b1.o_idex_bubble), 0);
    chk("rst_freeze",    32'(b1.o_freeze), 0);
    chk("rst_fwd_a",     32'(b1.o_fwd_a), 0);
    chk("rst_fwd_b",     32'(b1.o_fwd_b), 0);
    chk("rst_stall_cnt", b1.o_stall_cnt, 0);
    chk("rst_flush_cnt", b1.o_flush_cnt, 0);
    tick();

    // 2: lw x5 ; add x6,x5,x7 -> one stall, then fwd_a=10
    instr(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    chk("lw_issue_pc_wen", 32'(b1.o_pc_wen), 1);
    tick();
    instr(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    chk("lu_pc_wen",   32'(b1.o_pc_wen), 0);
    chk("lu_ifid_wen", 32'(b1.o_ifid_wen), 0);
    chk("lu_bubble",   32'(b1.o_idex_bubble), 1);
    tick();
    chk("lu_next_pc_wen", 32'(b1.o_pc_wen), 1);
    chk("lu_next_bubble", 32'(b1.o_idex_bubble), 0);
    tick();
    idle();
    chk("lu_fwd_a",     32'(b1.o_fwd_a), 2);
    chk("lu_fwd_b",     32'(b1.o_fwd_b), 0);
    chk("lu_stall_cnt", b1.o_stall_cnt, 1);
    tick();

    // 3: add x5 ; sub x6,x5,x5 -> no stall, fwd 01/01; then the x0 variant
    instr(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    instr(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    chk("alu_pc_wen", 32'(b1.o_pc_wen), 1);
    chk("alu_bubble", 32'(b1.o_idex_bubble), 0);
    tick();
    idle();
    chk("alu_fwd_a", 32'(b1.o_fwd_a), 1);
    chk("alu_fwd_b", 32'(b1.o_fwd_b), 1);
    tick();
    instr(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    tick();
    instr(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    chk("x0_pc_wen", 32'(b1.o_pc_wen), 1);
    tick();
    idle();
    chk("x0_fwd_a",     32'(b1.o_fwd_a), 0);
    chk("x0_fwd_b",     32'(b1.o_fwd_b), 0);
    chk("x0_stall_cnt", b1.o_stall_cnt, 1);
    tick();

    // 4: load-use hazard together with a redirect -> redirect wins
    instr(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    instr(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    redirect = 1'b1;
    #1;
    chk("rd_flush",  32'(b1.o_ifid_flush), 1);
    chk("rd_bubble", 32'(b1.o_idex_bubble), 1);
    chk("rd_pc_wen", 32'(b1.o_pc_wen), 1);
    tick();
    redirect = 1'b0;
    idle();
    chk("rd_flush_cnt", b1.o_flush_cnt, 1);
    chk("rd_stall_cnt", b1.o_stall_cnt, 1);
    tick();

    // 5: busy for 3 cycles with a pending redirect
    instr(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    instr(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    idle();
    redirect = 1'b1;
    busy = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("busy_freeze", 32'(b1.o_freeze), 1);
      chk("busy_flush",  32'(b1.o_ifid_flush), 0);
      chk("busy_pc_wen", 32'(b1.o_pc_wen), 0);
      chk("busy_fwd_a",  32'(b1.o_fwd_a), 1);
      tick();
    end
    chk("busy_ex_rd",  32'(u1.ex_q.rd), 10);
    chk("busy_mem_rd", 32'(u1.mem_q.rd), 9);
    chk("busy_flush_cnt", b1.o_flush_cnt, 1);
    busy = 1'b0;
    #1;
    chk("unbusy_freeze", 32'(b1.o_freeze), 0);
    chk("unbusy_flush",  32'(b1.o_ifid_flush), 1);
    tick();
    redirect = 1'b0;
    #1;
    chk("unbusy_flush_cnt", b1.o_flush_cnt, 2);
    tick();

    // 6: no-forwarding instance, addi x1 ; addi x2,x1,1 -> 2 stalls
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk("nb_rst_stall_cnt", b0.o_stall_cnt, 0);
    instr(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0);
    chk("nb_issue_pc_wen", 32'(b0.o_pc_wen), 1);
    tick();
    instr(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
    chk("nb_stall1_pc_wen", 32'(b0.o_pc_wen), 0);
    chk("nb_stall1_bubble", 32'(b0.o_idex_bubble), 1);
    tick();
    chk("nb_stall2_pc_wen", 32'(b0.o_pc_wen), 0);
    chk("nb_stall2_cnt",    b0.o_stall_cnt, 1);
    tick();
    chk("nb_go_pc_wen", 32'(b0.o_pc_wen), 1);
    chk("nb_stall_cnt", b0.o_stall_cnt, 2);
    tick();
    idle();
    chk("nb_fwd_a", 32'(b0.o_fwd_a), 0);
    instr(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    instr(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
    chk("nb_mid_pc_wen", 32'(b0.o_pc_wen), 0);
    rst = 1'b1;
    #1;
    chk("nb_rst_pc_wen",  32'(b0.o_pc_wen), 1);
    chk("nb_rst_bubble",  32'(b0.o_idex_bubble), 0);
    chk("nb_rst_cnt",     b0.o_stall_cnt, 0);
    rst = 1'b0;
    tick();
    chk("nb_post_rst_cnt", b0.o_stall_cnt, 0);
    idle();
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
